prng_byte_arbiter: RTL and testbench
====================================

# prng_byte_arbiter

Shares one 8-bit Fibonacci LFSR (p(x) = x^8 + x^6 + x^5 + x^4 + 1, 255 states, serial MSB output) between N_REQ requesters that each need whole pseudo-random bytes. The block round-robin arbitrates requests and steps the LFSR eight times per grant. It collects the serial bits MSB-first into a byte and returns it with a one-cycle valid pulse tagged with the requester id. It also owns LFSR seeding, so no requester touches the generator directly.

## Interface
- N_REQ, default 4: number of requesters, 2..8
- ID_W, default $clog2(N_REQ): width of o_id
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- i_req  in  N_REQ  per-requester request level
- i_reseed  in  1  load i_seed into LFSR; accepted only in IDLE
- i_seed  in  8  seed value; 8'h00 is replaced by 8'h01
- o_gnt  out  N_REQ  one-hot grant, held SHIFT..DONE
- o_valid  out  1  byte-ready pulse, DONE state only
- o_data  out  8  collected byte, meaningful when o_valid
- o_id  out  ID_W  index of granted requester
- o_busy  out  1  state != IDLE

## Operation
- LFSR: state s[7:0]; each step s <= {s[6:0], s[7]^s[5]^s[4]^s[3]}; serial bit = s[7] before the step. Reset/seed-zero state is 8'h01. LFSR state persists across grants; it is never cleared by arbitration.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - i_reseed=1: load seed; no grant this cycle (reseed beats requests).
  - Otherwise, any i_req: pick winner round-robin starting at pointer; register o_id/o_gnt; cnt<=0; go SHIFT.
- SHIFT: step LFSR every cycle; byte <= {byte[6:0], s[7]}; cnt++. After 8th step go DONE.
- DONE: o_valid=1, o_data=byte, o_gnt still asserted. pointer <= o_id+1 (mod N_REQ).
  - Re-arbitrate with the served requester's i_req masked. If any other i_req is high, go directly to SHIFT with the new grant; else go IDLE.
  - i_reseed is ignored in DONE.
- Requester protocol:
  - Hold i_req until o_valid with matching o_id.
  - Deassert the following cycle to avoid a repeat grant.
  - Dropping i_req during SHIFT does not abort; the byte is still produced and delivered.
- i_reseed in SHIFT/DONE: ignored, not queued. Caller gates on !o_busy.
- Round-robin fairness: with all requesters asserting, grants cycle 0,1,…,N_REQ-1,0.

## Timing
- Reset values: state IDLE, LFSR 8'h01, pointer 0, o_gnt 0, o_valid 0, o_data 0, o_id 0, o_busy 0.
- Reset applies mid-operation at the next edge regardless of state. The in-flight byte is discarded and no o_valid is issued.
- Latency: request sampled in IDLE at edge k → o_gnt/o_busy high after edge k. Eight SHIFT cycles (edges k+1..k+8). o_valid high during the cycle after edge k+8, 9 cycles after request.
- Back-to-back service from DONE: one byte every 9 cycles.
- o_data holds its last value outside DONE; it only changes when DONE is entered.
- Seed load in IDLE at edge k takes effect for a grant sampled at edge k+1 or later.

## Structure
- Package prng_pkg:
  - LFSR_W=8, LFSR_TAPS=8'hB8 (bits 7,5,4,3), LFSR_RESET=8'h01.
  - Typedef state_t {IDLE, SHIFT, DONE}.
- Sub-module lfsr_core:
  - Ports clk, rst, i_step, i_load, i_seed[7:0], o_bit (= s[7]).
  - Synchronous active-high reset to LFSR_RESET; i_load beats i_step; zero seed mapped to LFSR_RESET inside.
- Round-robin picker inline (rotate-priority encode), no separate module.

## Test plan
- After reset, i_req=4'b0001 → o_valid 9 cycles later, o_id=0, o_data=8'h01. Second request → o_data=8'h1C.
- i_req=4'b1111 held → o_id sequence 0,1,2,3,0 with o_valid every 9 cycles and no IDLE gaps.
- i_reseed=1, i_seed=8'h00 in IDLE, same cycle i_req=4'b0010 → no grant that cycle. Next cycle grant id 1, byte 8'h01.
- i_req[2] pulsed one cycle then dropped → full SHIFT runs, o_valid with o_id=2 still delivered.
- rst=1 at 4th SHIFT cycle → next cycle all outputs zero, state IDLE. Next request yields 8'h01.
- i_reseed during SHIFT → ignored; the running byte and the following byte match the unseeded sequence.

Source files
------------

// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the PRNG byte arbiter: LFSR geometry, tap mask,
// reset/seed-zero state, arbiter FSM encoding and the single-step LFSR
// next-state function used by lfsr_core.
// -----------------------------------------------------------------------------
package prng_pkg;

  localparam int LFSR_W = 8;

  // p(x) = x^8 + x^6 + x^5 + x^4 + 1 in left-shifting Fibonacci form:
  // feedback is s[7]^s[5]^s[4]^s[3].
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;

  // One serial bit per step, so one byte costs LFSR_W steps.
  localparam int BYTE_STEPS = LFSR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
// 8-bit Fibonacci LFSR with synchronous seed load and serial MSB output.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, state <= LFSR_RESET
//   i_step  in   advance the LFSR one step
//   i_load  in   load i_seed (wins over i_step)
//   i_seed  in   seed; the all-zero lock-up state is replaced by LFSR_RESET
//   o_bit   out  serial output, s[7] of the current state
// -----------------------------------------------------------------------------
module lfsr_core
  import prng_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic              o_bit
);

  logic [LFSR_W-1:0] s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= LFSR_RESET;
    end else if (i_load) begin
      // All-zero is the one state an XOR LFSR can never leave.
      s_q <= (i_seed == '0) ? LFSR_RESET : i_seed;
    end else if (i_step) begin
      s_q <= lfsr_next(s_q);
    end
  end

  assign o_bit = s_q[LFSR_W-1];

endmodule

// File: rtl/prng_byte_arbiter.sv
// -----------------------------------------------------------------------------
// prng_byte_arbiter
// Shares one LFSR between N_REQ requesters. A round-robin pick grants one
// requester, the LFSR is stepped eight times while the serial bits are
// collected MSB-first, and the byte is returned with a one-cycle o_valid
// tagged with o_id. Seeding is owned here and only accepted while idle.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   i_req     in   per-requester request level (hold until served)
//   i_reseed  in   load i_seed into the LFSR; honoured only in IDLE
//   i_seed    in   seed value (8'h00 maps to 8'h01)
//   o_gnt     out  one-hot grant, held from SHIFT through DONE
//   o_valid   out  byte-ready pulse, high in DONE only
//   o_data    out  collected byte, updated on entry to DONE
//   o_id      out  index of the granted requester
//   o_busy    out  high whenever the FSM is not IDLE
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no grant; accepts reseed, otherwise arbitrates from ptr_q
// SHIFT | grant held; LFSR stepped and one bit collected per cycle (8 cycles)
// DONE  | o_valid pulse; re-arbitrate with the served requester masked
// -----------------------------------------------------------------------------
module prng_byte_arbiter
  import prng_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  i_req,
  input  logic              i_reseed,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [N_REQ-1:0]  o_gnt,
  output logic              o_valid,
  output logic [LFSR_W-1:0] o_data,
  output logic [ID_W-1:0]   o_id,
  output logic              o_busy
);

  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [2:0]      LAST_STEP = 3'(BYTE_STEPS - 1);
  localparam logic [ID_W:0]   N_REQ_W   = (ID_W + 1)'(N_REQ);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q;
  logic [LFSR_W-2:0]   shift_q;
  logic [LFSR_W-1:0]   data_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     ptr_q;

  logic [ID_W-1:0]     next_ptr;
  logic [ID_W-1:0]     arb_start;
  logic [N_REQ-1:0]    arb_req;
  logic [ID_W:0]       idx;
  logic                win_any;
  logic [ID_W-1:0]     win_id;
  logic [N_REQ-1:0]    win_gnt;
  logic                take_grant;
  logic                last_step;
  logic                lfsr_step;
  logic                lfsr_load;
  logic                lfsr_bit;

  lfsr_core u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_step (lfsr_step),
    .i_load (lfsr_load),
    .i_seed (i_seed),
    .o_bit  (lfsr_bit)
  );

  // Pointer value that takes effect once the current grant completes.
  assign next_ptr  = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
  assign last_step = (cnt_q == LAST_STEP);

  // In DONE the served requester may still be holding i_req for this cycle,
  // so it is masked and the search starts one past it. That start equals
  // the pointer being written, so IDLE and DONE arbitration agree.
  always_comb begin
    arb_req   = i_req;
    arb_start = ptr_q;
    if (state_q == DONE) begin
      arb_req   = i_req & ~gnt_q;
      arb_start = next_ptr;
    end
  end

  // Rotate-priority encode: scan from arb_start, wrapping at N_REQ, and take
  // the first requester found.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    win_gnt = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, arb_start} + (ID_W + 1)'(i);
      if (idx >= N_REQ_W) begin
        idx = idx - N_REQ_W;
      end
      if (!win_any && arb_req[idx[ID_W-1:0]]) begin
        win_any = 1'b1;
        win_id  = idx[ID_W-1:0];
      end
    end
    win_gnt[win_id] = win_any;
  end

  always_comb begin
    state_d    = state_q;
    lfsr_step  = 1'b0;
    lfsr_load  = 1'b0;
    take_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A reseed costs the requesters one cycle; they are served after.
        if (i_reseed) begin
          lfsr_load = 1'b1;
        end else if (win_any) begin
          take_grant = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_step = 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (win_any) begin
          take_grant = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;

      if (take_grant) begin
        gnt_q <= win_gnt;
        id_q  <= win_id;
        cnt_q <= '0;
      end else if (state_q == DONE) begin
        gnt_q <= '0;
      end

      if (state_q == SHIFT) begin
        shift_q <= {shift_q[LFSR_W-3:0], lfsr_bit};
        cnt_q   <= cnt_q + 3'd1;
        // Only the first seven bits are kept in shift_q; the eighth goes
        // straight into o_data so the output changes only on entry to DONE.
        if (last_step) begin
          data_q <= {shift_q, lfsr_bit};
        end
      end

      if (state_q == DONE) begin
        ptr_q <= next_ptr;
      end
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = (state_q == DONE);
  assign o_data  = data_q;
  assign o_id    = id_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_prng_byte_arbiter.sv
module tb_prng_byte_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  i_req;
  logic          i_reseed;
  logic [7:0]    i_seed;
  logic [N-1:0]  o_gnt;
  logic          o_valid;
  logic [7:0]    o_data;
  logic [IW-1:0] o_id;
  logic          o_busy;

  always #5 clk = ~clk;

  prng_byte_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_reseed (i_reseed),
    .i_seed   (i_seed),
    .o_gnt    (o_gnt),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_id     (o_id),
    .o_busy   (o_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] m_lfsr;

  typedef struct {
    logic [N-1:0] req;
    int           n;
    int           ids[4];
  } vec_t;

  vec_t tbl[8];

  // Independent reference: eight steps of s <= {s[6:0], s7^s5^s4^s3}.
  function automatic logic [7:0] step8(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = {t[6:0], t[7] ^ t[5] ^ t[4] ^ t[3]};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected byte for the next grant is the model state; then advance it.
  task automatic push(input int id);
    exp_t e;
    e.id   = IW'(id);
    e.data = m_lfsr;
    sb.push_back(e);
    m_lfsr = step8(m_lfsr);
  endtask

  task automatic push_lit(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = IW'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  // Requesters drop their line when they see their own o_valid; returns once
  // every expected byte has been delivered and the block is idle.
  task automatic serve(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      if (o_valid) i_req[o_id] = 1'b0;
      if (sb.size() == 0 && !o_busy) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL serve_timeout: %0d bytes outstanding, busy=%0b req=%b", sb.size(), o_busy, i_req);
      sb.delete();
      i_req = '0;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    i_req    = '0;
    i_reseed = 1'b0;
    i_seed   = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_lfsr = 8'h01;
    sb.delete();
  endtask

  // Scoreboard consumer: every o_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: id=%0d data=%02h (t=%0t)", o_id, o_data, $time);
      end else begin
        mon_e = sb.pop_front();
        check("valid_id", o_id, mon_e.id);
        check("valid_data", o_data, mon_e.data);
        check("valid_gnt", o_gnt, 4'b0001 << mon_e.id);
        check("valid_busy", o_busy, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit early;
    bit gap;
    bit seen;
    int nv;
    int cyc;
    int last;
    int exp_ids[5];

    // Round-robin vectors; pointer is 1 when the table starts and the
    // expected id order is worked out by hand from that pointer.
    tbl[0] = '{4'b1111, 4, '{1, 2, 3, 0}};
    tbl[1] = '{4'b0101, 2, '{2, 0, 0, 0}};
    tbl[2] = '{4'b1010, 2, '{1, 3, 0, 0}};
    tbl[3] = '{4'b1000, 1, '{3, 0, 0, 0}};
    tbl[4] = '{4'b0110, 2, '{1, 2, 0, 0}};
    tbl[5] = '{4'b1001, 2, '{3, 0, 0, 0}};
    tbl[6] = '{4'b0100, 1, '{2, 0, 0, 0}};
    tbl[7] = '{4'b0011, 2, '{0, 1, 0, 0}};
    exp_ids = '{0, 1, 2, 3, 0};

    // Reset values
    rst = 1'b1; i_req = '0; i_reseed = 1'b0; i_seed = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", o_gnt, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_id", o_id, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;
    m_lfsr = 8'h01;

    // First byte after reset: latency and value 8'h01
    @(negedge clk);
    i_req = 4'b0001;
    push_lit(0, 8'h01);
    @(negedge clk);
    check("lat_busy", o_busy, 1);
    check("lat_gnt", o_gnt, 4'b0001);
    check("lat_valid_low", o_valid, 0);
    early = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (o_valid) early = 1'b1;
    end
    check("lat_no_early_valid", early, 0);
    @(negedge clk);
    check("lat_valid_at_9", o_valid, 1);
    i_req = '0;
    serve(20);
    check("idle_gnt_clear", o_gnt, 0);
    check("data_held_in_idle", o_data, 8'h01);

    // Second byte from the continuing sequence: 8'h1C
    i_req = 4'b0001;
    push_lit(0, 8'h1C);
    serve(30);
    m_lfsr = step8(8'h1C);

    // Table-driven round-robin vectors
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      i_req = tbl[v].req;
      for (int k = 0; k < tbl[v].n; k++) push(tbl[v].ids[k]);
      serve(120);
    end

    // All requesters held: ids 0,1,2,3,0, a byte every 9 cycles, never idle
    do_reset();
    @(negedge clk);
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) push(exp_ids[k]);
    nv = 0; cyc = 0; last = 0; gap = 1'b0;
    for (int c = 0; c < 80 && nv < 5; c++) begin
      @(negedge clk);
      cyc++;
      if (!o_busy) gap = 1'b1;
      if (o_valid) begin
        if (nv > 0) check("hold_spacing", cyc - last, 9);
        last = cyc;
        nv++;
        if (nv == 5) i_req = '0;
      end
    end
    check("hold_valid_count", nv, 5);
    check("hold_no_idle_gap", gap, 0);
    serve(20);

    // Reseed with zero beats a same-cycle request; grant follows next cycle
    @(negedge clk);
    i_reseed = 1'b1;
    i_seed   = 8'h00;
    i_req    = 4'b0010;
    @(negedge clk);
    check("reseed_no_gnt", o_gnt, 0);
    check("reseed_not_busy", o_busy, 0);
    i_reseed = 1'b0;
    push_lit(1, 8'h01);
    @(negedge clk);
    check("post_reseed_gnt", o_gnt, 4'b0010);
    serve(30);
    m_lfsr = step8(8'h01);

    // Nonzero seed is taken as-is
    @(negedge clk);
    i_reseed = 1'b1;
    i_seed   = 8'hA5;
    @(negedge clk);
    i_reseed = 1'b0;
    i_req    = 4'b0001;
    push_lit(0, 8'hA5);
    serve(30);
    m_lfsr = step8(8'hA5);

    // Request pulsed for one cycle still delivers the byte
    @(negedge clk);
    i_req = 4'b0100;
    push(2);
    @(negedge clk);
    i_req = '0;
    check("pulse_busy", o_busy, 1);
    serve(30);

    // Reset in the 4th SHIFT cycle discards the byte
    @(negedge clk);
    i_req = 4'b0001;
    @(negedge clk);
    i_req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_gnt", o_gnt, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_id", o_id, 0);
    check("midrst_busy", o_busy, 0);
    rst = 1'b0;
    m_lfsr = 8'h01;
    repeat (12) @(negedge clk);
    i_req = 4'b0001;
    push_lit(0, 8'h01);
    serve(30);

    // Reseed held across SHIFT and DONE is ignored
    do_reset();
    @(negedge clk);
    i_req = 4'b0011;
    push(0);
    push(1);
    repeat (2) @(negedge clk);
    i_reseed = 1'b1;
    i_seed   = 8'h5A;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("busy_reseed_first_valid", seen, 1);
    i_req[0] = 1'b0;
    @(negedge clk);
    i_reseed = 1'b0;
    check("busy_reseed_next_gnt", o_gnt, 4'b0010);
    serve(30);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
